// File: rtl/da_pack_pkg.sv
// da_pack_pkg: shared defaults and types for the DA sample packer.
//   DA_LANES / DA_SAMPLE_W : default lane count per rail and sample width
//   sample_t               : one sample
//   jesd_word_t            : one packed output word (I lanes low, Q lanes high)
//   pack_state_e           : packer FSM states
package da_pack_pkg;

  localparam int DA_LANES    = 8;
  localparam int DA_SAMPLE_W = 16;

  typedef logic [DA_SAMPLE_W-1:0]            sample_t;
  typedef logic [2*DA_LANES*DA_SAMPLE_W-1:0] jesd_word_t;

  typedef enum logic {
    PRIME  = 1'b0,
    STREAM = 1'b1
  } pack_state_e;

endpackage

// File: rtl/da_lane_fifo.sv
// da_lane_fifo: single-clock FIFO for one sample lane.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   wr_valid, wr_data  write request and data; accepted only when not full
//   pop, rd_data       pop request and head-of-queue data (combinational read)
//   full, empty        flags decoded from the registered count
//   count              registered occupancy
// A full FIFO that is popped accepts a new write only on the following
// cycle, because full is decoded from the registered count.
module da_lane_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = wr_valid && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/da_sample_packer.sv
// da_sample_packer: buffers 2*LANES independent sample lanes (I and Q rails),
// realigns them and emits one packed word per beat to the JESD204B DA core.
// Underflow produces an all-zero beat and re-primes the lane FIFOs.
//
// Ports:
//   clk_250m, sys_rst_n          clock, synchronous active-low reset
//   s_axis_daI_*                 per-lane I sample streams (valid/ready/data/last)
//   s_axis_daQ_*                 per-lane Q sample streams
//   m_axis_jesd_*                packed output stream; valid is 1 out of reset
//   underflow_cnt                saturating count of underflow beats
//   frame_cnt                    wrapping count of tlast beats sent
//   skew_err                     sticky: lane tlast bits disagreed on a beat
//   tp_en                        (only with DA_TEST_PATTERN_EN) ramp test pattern
//
// Optional feature macro: DA_TEST_PATTERN_EN
//
// state  | meaning
// PRIME  | output zeros, wait until every FIFO holds START_LEVEL entries
// STREAM | pop all lanes per accepted beat; any empty lane -> zero beat, PRIME
module da_sample_packer
  import da_pack_pkg::*;
#(
  parameter int LANES       = DA_LANES,
  parameter int SAMPLE_W    = DA_SAMPLE_W,
  parameter int FIFO_DEPTH  = 16,
  parameter int START_LEVEL = 4
) (
  input  logic                        clk_250m,
  input  logic                        sys_rst_n,
`ifdef DA_TEST_PATTERN_EN
  input  logic                        tp_en,
`endif
  input  logic [LANES-1:0]            s_axis_daI_tvalid,
  output logic [LANES-1:0]            s_axis_daI_tready,
  input  logic [LANES*SAMPLE_W-1:0]   s_axis_daI_tdata,
  input  logic [LANES-1:0]            s_axis_daI_tlast,
  input  logic [LANES-1:0]            s_axis_daQ_tvalid,
  output logic [LANES-1:0]            s_axis_daQ_tready,
  input  logic [LANES*SAMPLE_W-1:0]   s_axis_daQ_tdata,
  input  logic [LANES-1:0]            s_axis_daQ_tlast,
  output logic                        m_axis_jesd_tvalid,
  input  logic                        m_axis_jesd_tready,
  output logic [2*LANES*SAMPLE_W-1:0] m_axis_jesd_tdata,
  output logic                        m_axis_jesd_tlast,
  output logic [15:0]                 underflow_cnt,
  output logic [31:0]                 frame_cnt,
  output logic                        skew_err
);

  localparam int NL = 2 * LANES;
  localparam int WW = NL * SAMPLE_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] START_CNT = CW'(START_LEVEL);

  // Lane i < LANES is I lane i, lane i >= LANES is Q lane i-LANES; this is
  // exactly the packing order of the output word.
  logic [NL-1:0] in_valid;
  logic [NL-1:0] in_last;
  logic [WW-1:0] in_data;
  logic [NL-1:0] f_full;
  logic [NL-1:0] f_empty;
  logic [NL-1:0] f_last;
  logic [NL-1:0] level_ok;
  logic [NL-1:0] pop;
  logic [WW-1:0] fifo_word;
  logic [CW-1:0] f_count [NL];

  assign in_valid = {s_axis_daQ_tvalid, s_axis_daI_tvalid};
  assign in_last  = {s_axis_daQ_tlast, s_axis_daI_tlast};
  assign in_data  = {s_axis_daQ_tdata, s_axis_daI_tdata};

  assign s_axis_daI_tready = ~f_full[LANES-1:0];
  assign s_axis_daQ_tready = ~f_full[NL-1:LANES];

  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic [SAMPLE_W:0] rd_word;

    da_lane_fifo #(
      .WIDTH (SAMPLE_W + 1),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk_250m),
      .rst_n    (sys_rst_n),
      .wr_valid (in_valid[i]),
      .wr_data  ({in_last[i], in_data[SAMPLE_W*i +: SAMPLE_W]}),
      .pop      (pop[i]),
      .rd_data  (rd_word),
      .full     (f_full[i]),
      .empty    (f_empty[i]),
      .count    (f_count[i])
    );

    assign fifo_word[SAMPLE_W*i +: SAMPLE_W] = rd_word[SAMPLE_W-1:0];
    assign f_last[i]   = rd_word[SAMPLE_W];
    assign level_ok[i] = (f_count[i] >= START_CNT);
  end

  logic tp_active;
`ifdef DA_TEST_PATTERN_EN
  logic [SAMPLE_W-1:0] ramp;
  logic [WW-1:0]       tp_word;

  assign tp_active = tp_en;

  always_comb begin
    tp_word = '0;
    for (int l = 0; l < LANES; l++) begin
      tp_word[SAMPLE_W*l +: SAMPLE_W]         = ramp + SAMPLE_W'(l);
      tp_word[SAMPLE_W*(LANES+l) +: SAMPLE_W] = ~(ramp + SAMPLE_W'(l));
    end
  end
`else
  assign tp_active = 1'b0;
`endif

  pack_state_e state;
  pack_state_e state_next;
  logic        load_data;
  logic        load_zero;
  logic        underflow;
  logic        all_primed;
  logic        all_ready;

  assign all_primed = &level_ok;
  assign all_ready  = ~|f_empty;

  always_ff @(posedge clk_250m) begin
    if (!sys_rst_n) state <= PRIME;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = '0;
    load_data  = 1'b0;
    load_zero  = 1'b0;
    underflow  = 1'b0;
    case (state)
      PRIME: begin
        load_zero = m_axis_jesd_tready;
        if (all_primed) state_next = STREAM;
      end
      STREAM: begin
        if (m_axis_jesd_tready) begin
          if (all_ready) begin
            pop       = '1;
            load_data = 1'b1;
          end else begin
            load_zero  = 1'b1;
            underflow  = 1'b1;
            state_next = PRIME;
          end
        end
      end
      default: state_next = PRIME;
    endcase
    // Test pattern bypasses the FSM; lanes keep draining so they do not stall.
    if (tp_active) begin
      state_next = PRIME;
      load_data  = 1'b0;
      load_zero  = 1'b0;
      underflow  = 1'b0;
      pop        = m_axis_jesd_tready ? ~f_empty : '0;
    end
  end

  always_ff @(posedge clk_250m) begin
    if (!sys_rst_n) begin
      m_axis_jesd_tvalid <= 1'b0;
      m_axis_jesd_tdata  <= '0;
      m_axis_jesd_tlast  <= 1'b0;
      underflow_cnt      <= '0;
      frame_cnt          <= '0;
      skew_err           <= 1'b0;
`ifdef DA_TEST_PATTERN_EN
      ramp               <= '0;
`endif
    end else begin
      m_axis_jesd_tvalid <= 1'b1;
      if (load_data) begin
        m_axis_jesd_tdata <= fifo_word;
        m_axis_jesd_tlast <= f_last[0];
        if (f_last[0]) frame_cnt <= frame_cnt + 32'd1;
        if (!((&f_last) || !(|f_last))) skew_err <= 1'b1;
      end else if (load_zero) begin
        m_axis_jesd_tdata <= '0;
        m_axis_jesd_tlast <= 1'b0;
      end
      if (underflow && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
`ifdef DA_TEST_PATTERN_EN
      if (tp_active && m_axis_jesd_tready) begin
        m_axis_jesd_tdata <= tp_word;
        m_axis_jesd_tlast <= 1'b0;
        ramp              <= ramp + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_da_sample_packer.sv
// tb_da_sample_packer: scoreboard bench for da_sample_packer.
// Every lane carries the same index sequence (I = 0x1000+n, Q = 0x2000+n), so
// the n-th non-zero output word is fully determined by n; expected words are
// queued when lane 0 I accepts sample n and popped when a non-zero word emerges.
// Build with DA_TEST_PATTERN_EN to also exercise the ramp test pattern.
module tb_da_sample_packer;
  import da_pack_pkg::*;

  localparam int LANES       = 8;
  localparam int SAMPLE_W    = 16;
  localparam int FIFO_DEPTH  = 16;
  localparam int START_LEVEL = 4;
  localparam int WW          = 2 * LANES * SAMPLE_W;
  localparam int BIG         = 1 << 30;

  typedef struct {
    int         idx;
    jesd_word_t word;
    logic       last;
  } exp_t;

  logic                      clk_250m = 1'b0;
  logic                      sys_rst_n;
  logic [LANES-1:0]          s_axis_daI_tvalid;
  logic [LANES-1:0]          s_axis_daI_tready;
  logic [LANES*SAMPLE_W-1:0] s_axis_daI_tdata;
  logic [LANES-1:0]          s_axis_daI_tlast;
  logic [LANES-1:0]          s_axis_daQ_tvalid;
  logic [LANES-1:0]          s_axis_daQ_tready;
  logic [LANES*SAMPLE_W-1:0] s_axis_daQ_tdata;
  logic [LANES-1:0]          s_axis_daQ_tlast;
  logic                      m_axis_jesd_tvalid;
  logic                      m_axis_jesd_tready;
  logic [WW-1:0]             m_axis_jesd_tdata;
  logic                      m_axis_jesd_tlast;
  logic [15:0]               underflow_cnt;
  logic [31:0]               frame_cnt;
  logic                      skew_err;
`ifdef DA_TEST_PATTERN_EN
  logic                      tp_en;
`endif

  always #2 clk_250m = ~clk_250m;

  da_sample_packer #(
    .LANES       (LANES),
    .SAMPLE_W    (SAMPLE_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .START_LEVEL (START_LEVEL)
  ) dut (
    .clk_250m           (clk_250m),
    .sys_rst_n          (sys_rst_n),
`ifdef DA_TEST_PATTERN_EN
    .tp_en              (tp_en),
`endif
    .s_axis_daI_tvalid  (s_axis_daI_tvalid),
    .s_axis_daI_tready  (s_axis_daI_tready),
    .s_axis_daI_tdata   (s_axis_daI_tdata),
    .s_axis_daI_tlast   (s_axis_daI_tlast),
    .s_axis_daQ_tvalid  (s_axis_daQ_tvalid),
    .s_axis_daQ_tready  (s_axis_daQ_tready),
    .s_axis_daQ_tdata   (s_axis_daQ_tdata),
    .s_axis_daQ_tlast   (s_axis_daQ_tlast),
    .m_axis_jesd_tvalid (m_axis_jesd_tvalid),
    .m_axis_jesd_tready (m_axis_jesd_tready),
    .m_axis_jesd_tdata  (m_axis_jesd_tdata),
    .m_axis_jesd_tlast  (m_axis_jesd_tlast),
    .underflow_cnt      (underflow_cnt),
    .frame_cnt          (frame_cnt),
    .skew_err           (skew_err)
  );

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_data   = 0;
  int         n_zero   = 0;
  int         last_idx = -1;
  jesd_word_t last_word = '0;
  int         ni[LANES];
  int         nq[LANES];
  int         lim_i[LANES];
  int         lim_q[LANES];
  logic       rst_drv;
  logic       rdy_drv;
  logic       drv_en;
  logic       tp_mode;

  task automatic check_val(input string tag, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic tl_of(input bit is_i, input int lane, input int n);
    return (n == 63) || (is_i && lane == 0 && n == 127);
  endfunction

  function automatic jesd_word_t word_of(input int n);
    jesd_word_t w;
    w = '0;
    for (int l = 0; l < LANES; l++) begin
      w[SAMPLE_W*l +: SAMPLE_W]         = 16'h1000 + 16'(n);
      w[SAMPLE_W*(LANES+l) +: SAMPLE_W] = 16'h2000 + 16'(n);
    end
    return w;
  endfunction

`ifdef DA_TEST_PATTERN_EN
  function automatic jesd_word_t tp_word_of(input int b);
    jesd_word_t w;
    logic [15:0] v;
    w = '0;
    for (int l = 0; l < LANES; l++) begin
      v = 16'(b + l);
      w[SAMPLE_W*l +: SAMPLE_W]         = v;
      w[SAMPLE_W*(LANES+l) +: SAMPLE_W] = ~v;
    end
    return w;
  endfunction
`endif

  task automatic observe();
    exp_t e;
    if (m_axis_jesd_tdata != '0) begin
      if (sb.size() == 0) begin
        check_val("unexpected_word", m_axis_jesd_tdata, '0);
      end else begin
        e = sb.pop_front();
        check_val($sformatf("word%0d", e.idx), m_axis_jesd_tdata, e.word);
        check_val($sformatf("tlast%0d", e.idx), WW'(m_axis_jesd_tlast), WW'(e.last));
        last_word = e.word;
        last_idx  = e.idx;
        n_data++;
        if (e.idx == 63) begin
          check_val("frame_cnt_63", WW'(frame_cnt), WW'(1));
          check_val("skew_err_63", WW'(skew_err), WW'(0));
        end
        if (e.idx == 127) begin
          check_val("frame_cnt_127", WW'(frame_cnt), WW'(2));
          check_val("skew_err_127", WW'(skew_err), WW'(1));
        end
      end
    end else begin
      n_zero++;
      check_val("zero_beat_tlast", WW'(m_axis_jesd_tlast), WW'(0));
    end
  endtask

  task automatic step();
    logic [LANES-1:0] acc_i;
    logic [LANES-1:0] acc_q;
    logic             rdy;
    logic             rst;
    exp_t             e;
    @(negedge clk_250m);
    sys_rst_n          = rst_drv;
    m_axis_jesd_tready = rdy_drv;
    for (int l = 0; l < LANES; l++) begin
      s_axis_daI_tvalid[l] = rst_drv && drv_en && (ni[l] < lim_i[l]);
      s_axis_daI_tdata[SAMPLE_W*l +: SAMPLE_W] = 16'h1000 + 16'(ni[l]);
      s_axis_daI_tlast[l] = tl_of(1'b1, l, ni[l]);
      s_axis_daQ_tvalid[l] = rst_drv && drv_en && (nq[l] < lim_q[l]);
      s_axis_daQ_tdata[SAMPLE_W*l +: SAMPLE_W] = 16'h2000 + 16'(nq[l]);
      s_axis_daQ_tlast[l] = tl_of(1'b0, l, nq[l]);
    end
    #1;
    acc_i = s_axis_daI_tvalid & s_axis_daI_tready;
    acc_q = s_axis_daQ_tvalid & s_axis_daQ_tready;
    rdy   = rdy_drv;
    rst   = rst_drv;
    @(posedge clk_250m);
    #1;
    for (int l = 0; l < LANES; l++) begin
      if (acc_i[l]) begin
        if (l == 0) begin
          e.idx  = ni[0];
          e.word = word_of(ni[0]);
          e.last = tl_of(1'b1, 0, ni[0]);
          sb.push_back(e);
        end
        ni[l]++;
      end
      if (acc_q[l]) nq[l]++;
    end
    if (rst && rdy && !tp_mode) observe();
  endtask

  task automatic run_until_data(input string tag, input int budget, output int zeros);
    int z0;
    int d0;
    int k;
    z0 = n_zero;
    d0 = n_data;
    k  = 0;
    while (n_data == d0 && k < budget) begin
      step();
      k++;
    end
    if (n_data == d0) check_val({tag, "_timeout"}, WW'(n_data), WW'(d0 + 1));
    zeros = n_zero - z0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_tvalid"}, WW'(m_axis_jesd_tvalid), WW'(0));
    check_val({tag, "_tdata"}, m_axis_jesd_tdata, '0);
    check_val({tag, "_tlast"}, WW'(m_axis_jesd_tlast), WW'(0));
    check_val({tag, "_underflow_cnt"}, WW'(underflow_cnt), WW'(0));
    check_val({tag, "_frame_cnt"}, WW'(frame_cnt), WW'(0));
    check_val({tag, "_skew_err"}, WW'(skew_err), WW'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int z;
    int z0;
    int k;
    rst_drv = 1'b0;
    rdy_drv = 1'b1;
    drv_en  = 1'b0;
    tp_mode = 1'b0;
`ifdef DA_TEST_PATTERN_EN
    tp_en = 1'b0;
`endif
    for (int l = 0; l < LANES; l++) begin
      ni[l] = 0; nq[l] = 0; lim_i[l] = BIG; lim_q[l] = BIG;
    end

    // Reset state.
    repeat (3) step();
    check_reset_outputs("reset");
    rst_drv = 1'b1;
    step();
    check_val("tvalid_after_reset", WW'(m_axis_jesd_tvalid), WW'(1));
    check_val("prime_zero_word", m_axis_jesd_tdata, '0);

    // Priming, then Q lane 3 stops after 10 samples.
    lim_q[3] = 10;
    drv_en   = 1'b1;
    run_until_data("prime", 50, z);
    check_val("prime_zero_beats", WW'(z), WW'(5));
    repeat (40) step();
    check_val("words_before_underflow", WW'(n_data), WW'(10));
    check_val("underflow_cnt_1", WW'(underflow_cnt), WW'(1));

    // Q3 resumes: restart needs 4 entries in Q3 plus the PRIME->STREAM edge.
    lim_q[3] = BIG;
    run_until_data("restart", 50, z);
    check_val("restart_zero_beats", WW'(z), WW'(5));
    z0 = n_zero;
    repeat (20) step();
    check_val("no_gap_after_restart", WW'(n_zero), WW'(z0));

    // Downstream backpressure.
    rdy_drv = 1'b0;
    repeat (20) step();
    check_val("hold_tdata", m_axis_jesd_tdata, last_word);
    check_val("hold_tvalid", WW'(m_axis_jesd_tvalid), WW'(1));
    check_val("hold_I_tready", WW'(s_axis_daI_tready), WW'(0));
    check_val("hold_Q_tready", WW'(s_axis_daQ_tready), WW'(0));
    check_val("hold_underflow_cnt", WW'(underflow_cnt), WW'(1));
    rdy_drv = 1'b1;

    // Stream through the frame ends at words 63 and 127.
    z0 = n_zero;
    k  = 0;
    while (last_idx < 130 && k < 400) begin
      step();
      k++;
    end
    if (last_idx < 130) check_val("frame_run_timeout", WW'(last_idx), WW'(130));
    check_val("no_gap_after_release", WW'(n_zero), WW'(z0));
    check_val("skew_err_sticky", WW'(skew_err), WW'(1));
    check_val("frame_cnt_final", WW'(frame_cnt), WW'(2));

    // Mid-stream reset for one cycle.
    rst_drv = 1'b0;
    step();
    check_reset_outputs("midreset");
    for (int l = 0; l < LANES; l++) begin
      ni[l] = 0; nq[l] = 0;
    end
    sb.delete();
    last_idx = -1;
    rst_drv  = 1'b1;
    run_until_data("reset_restart", 50, z);
    check_val("reset_restart_zero_beats", WW'(z), WW'(5));
    z0 = n_zero;
    repeat (10) step();
    check_val("no_gap_after_reset", WW'(n_zero), WW'(z0));

`ifdef DA_TEST_PATTERN_EN
    begin
      jesd_word_t tpq[$];
      jesd_word_t exp_w;
      drv_en  = 1'b0;
      tp_mode = 1'b1;
      tp_en   = 1'b1;
      for (int b = 0; b < 65540; b++) begin
        tpq.push_back(tp_word_of(b));
        step();
        exp_w = tpq.pop_front();
        if (b < 8 || b >= 65532) begin
          check_val($sformatf("tp_beat%0d", b), m_axis_jesd_tdata, exp_w);
          check_val($sformatf("tp_tlast%0d", b), WW'(m_axis_jesd_tlast), WW'(0));
        end
      end
      tp_en   = 1'b0;
      tp_mode = 1'b0;
      repeat (2) step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
